decoded_control: RTL and testbench
==================================

DECODED_CONTROL -- requirements
Module: decoder

Interface
REQ-001 Parameter DATA_BITS, default 8: immediate width; SHALL be <= 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 core_state  input  3  core FSM: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
REQ-005 instruction  input  32  fetched instruction word.
REQ-006 decoded_rd_address, decoded_rs_address, decoded_rt_address  output  8 each  register-file addresses.
REQ-007 decoded_predicate_address  output  2  predicate register P0-P3 select.
REQ-008 decoded_immediate  output  DATA_BITS  constant or branch target.
REQ-009 decoded_nzp  output  3  branch condition mask.
REQ-010 decoded_reg_write_enable, decoded_predicate_write_enable, decoded_nzp_write_enable  output  1 each  writeback strobes.
REQ-011 decoded_reg_input_mux  output  2  writeback source: 00 ALU, 01 LSU, 10 immediate, 11 tensor.
REQ-012 decoded_predicate_on, decoded_always_execute  output  1 each  predication controls.
REQ-013 decoded_mem_read_enable, decoded_mem_write_enable, decoded_tensor_enable  output  1 each  unit launch.
REQ-014 decoded_alu_arithmetic_mux  output  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; decoded_alu_output_mux  output  1  1 = compare result.
REQ-015 decoded_pc_mux, decoded_ret  output  1 each  branch select, thread return.
REQ-016 decoded_illegal  output  1  unsupported opcode seen.

Function
REQ-017 Fields SHALL be: opcode [31:28], predicate_on [27], predicate_address [26:25], always_execute [24], rd [23:16], rs [15:8], rt [7:0], immediate [DATA_BITS-1:0], nzp [23:21].
REQ-018 Outputs SHALL update only on the rising edge where core_state == DECODE and SHALL hold in all other states; latency 1 cycle, so outputs are valid in REQUEST.
REQ-019 On each DECODE edge, every control strobe SHALL first clear to 0, and then the opcode's strobes SHALL be set; no strobe carries over from a previous instruction.
REQ-020 Opcodes SHALL decode as follows:
- 0 NOP: no strobes.
- 1 BRnzp: pc_mux.
- 2 CMP: alu_output_mux, nzp_write_enable.
- 3/4/5/6 ADD/SUB/MUL/DIV: reg_write_enable, reg_input_mux 00, arithmetic_mux 00/01/10/11.
- 7 LDR: reg_write_enable, mem_read_enable, reg_input_mux 01.
- 8 STR: mem_write_enable.
- 9 CONST: reg_write_enable, reg_input_mux 10.
- A SETP: alu_output_mux, predicate_write_enable.
- B GEMM: tensor_enable, reg_write_enable, reg_input_mux 11.
- F RET: ret.
- C-E: illegal.
REQ-021 Address, predicate, immediate and nzp fields SHALL be latched for every opcode.
REQ-022 reg_write_enable SHALL be forced 0 when rd >= 13 (253-255 read-only, 13-252 unused).
REQ-023 always_execute SHALL be forced 0 whenever predicate_on is 0.
REQ-024 Back-to-back DECODE cycles SHALL each re-decode the current instruction.

Reset
REQ-025 A reset edge SHALL drive every output to 0 and clear decoded_illegal; reset takes priority over DECODE on the same edge.
REQ-026 Reset asserted mid-instruction (any core_state) SHALL discard the decoded instruction; no strobe is asserted on the cycle after reset.

Configuration
REQ-027 With DECODER_ILLEGAL_TRAP_EN defined, opcodes C-E SHALL set decoded_illegal, which stays sticky until reset; all strobes for that instruction SHALL be 0.
REQ-028 Without DECODER_ILLEGAL_TRAP_EN, opcodes C-E SHALL decode as NOP, and decoded_illegal SHALL be tied to 0.

Verification
REQ-029 reset high, then DECODE with 0x3005_0102 -> all outputs 0 after the reset edge; after release and DECODE: rd=5, rs=1, rt=2, reg_write_enable=1, mux=00, arith=00.
REQ-030 CONST 0x9003_00A5 in DECODE -> immediate=0xA5, reg_input_mux=10, reg_write_enable=1; state REQUEST with instruction changed to 0 -> outputs unchanged.
REQ-031 ADD with rd=0xFE (0x30FE_0102) -> reg_write_enable=0, rd=0xFE.
REQ-032 SETP 0xAA00_0304 -> predicate_write_enable=1, predicate_address=01, predicate_on=1, alu_output_mux=1; next, LDR 0x7001_0200 -> predicate_write_enable=0, mem_read_enable=1, mux=01.
REQ-033 opcode 0xD (0xD000_0000) -> with the macro: decoded_illegal=1, persists through a later NOP, cleared only by reset; without the macro: all outputs 0.

Source files
------------

// File: rtl/decoded_control.sv
// Instruction decoder: latches register/predicate/immediate fields and per-opcode control strobes on DECODE edges.
// Optional sticky illegal-opcode trap for opcodes C-E is enabled by defining DECODER_ILLEGAL_TRAP_EN.
module decoded_control #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           core_state,
    input  logic [31:0]          instruction,
    output logic [7:0]           decoded_rd_address,
    output logic [7:0]           decoded_rs_address,
    output logic [7:0]           decoded_rt_address,
    output logic [1:0]           decoded_predicate_address,
    output logic [DATA_BITS-1:0] decoded_immediate,
    output logic [2:0]           decoded_nzp,
    output logic                 decoded_reg_write_enable,
    output logic                 decoded_predicate_write_enable,
    output logic                 decoded_nzp_write_enable,
    output logic [1:0]           decoded_reg_input_mux,
    output logic                 decoded_predicate_on,
    output logic                 decoded_always_execute,
    output logic                 decoded_mem_read_enable,
    output logic                 decoded_mem_write_enable,
    output logic                 decoded_tensor_enable,
    output logic [1:0]           decoded_alu_arithmetic_mux,
    output logic                 decoded_alu_output_mux,
    output logic                 decoded_pc_mux,
    output logic                 decoded_ret,
    output logic                 decoded_illegal
);

    localparam logic [2:0] STATE_DECODE = 3'b010;

    logic [3:0] opcode;
    logic       rd_writable;
    logic       decode_edge;
    logic       illegal_op;

    logic       nx_reg_write_enable;
    logic       nx_predicate_write_enable;
    logic       nx_nzp_write_enable;
    logic [1:0] nx_reg_input_mux;
    logic       nx_mem_read_enable;
    logic       nx_mem_write_enable;
    logic       nx_tensor_enable;
    logic [1:0] nx_alu_arithmetic_mux;
    logic       nx_alu_output_mux;
    logic       nx_pc_mux;
    logic       nx_ret;

    assign opcode      = instruction[31:28];
    // Registers 13-255 are unused or read-only, so writes to them are suppressed.
    assign rd_writable = (instruction[23:16] < 8'd13);
    assign decode_edge = (core_state == STATE_DECODE);
    assign illegal_op  = (opcode >= 4'hC) && (opcode <= 4'hE);

    always_comb begin
        nx_reg_write_enable       = 1'b0;
        nx_predicate_write_enable = 1'b0;
        nx_nzp_write_enable       = 1'b0;
        nx_reg_input_mux          = 2'b00;
        nx_mem_read_enable        = 1'b0;
        nx_mem_write_enable       = 1'b0;
        nx_tensor_enable          = 1'b0;
        nx_alu_arithmetic_mux     = 2'b00;
        nx_alu_output_mux         = 1'b0;
        nx_pc_mux                 = 1'b0;
        nx_ret                    = 1'b0;
        case (opcode)
            4'h1: nx_pc_mux = 1'b1;
            4'h2: begin
                nx_alu_output_mux   = 1'b1;
                nx_nzp_write_enable = 1'b1;
            end
            4'h3, 4'h4, 4'h5, 4'h6: begin
                nx_reg_write_enable   = 1'b1;
                nx_alu_arithmetic_mux = 2'(opcode - 4'h3);
            end
            4'h7: begin
                nx_reg_write_enable = 1'b1;
                nx_mem_read_enable  = 1'b1;
                nx_reg_input_mux    = 2'b01;
            end
            4'h8: nx_mem_write_enable = 1'b1;
            4'h9: begin
                nx_reg_write_enable = 1'b1;
                nx_reg_input_mux    = 2'b10;
            end
            4'hA: begin
                nx_alu_output_mux         = 1'b1;
                nx_predicate_write_enable = 1'b1;
            end
            4'hB: begin
                nx_tensor_enable    = 1'b1;
                nx_reg_write_enable = 1'b1;
                nx_reg_input_mux    = 2'b11;
            end
            4'hF: nx_ret = 1'b1;
            default: ;
        endcase
        if (!rd_writable) begin
            nx_reg_write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            decoded_rd_address             <= '0;
            decoded_rs_address             <= '0;
            decoded_rt_address             <= '0;
            decoded_predicate_address      <= '0;
            decoded_immediate              <= '0;
            decoded_nzp                    <= '0;
            decoded_reg_write_enable       <= 1'b0;
            decoded_predicate_write_enable <= 1'b0;
            decoded_nzp_write_enable       <= 1'b0;
            decoded_reg_input_mux          <= '0;
            decoded_predicate_on           <= 1'b0;
            decoded_always_execute         <= 1'b0;
            decoded_mem_read_enable        <= 1'b0;
            decoded_mem_write_enable       <= 1'b0;
            decoded_tensor_enable          <= 1'b0;
            decoded_alu_arithmetic_mux     <= '0;
            decoded_alu_output_mux         <= 1'b0;
            decoded_pc_mux                 <= 1'b0;
            decoded_ret                    <= 1'b0;
        end else if (decode_edge) begin
            decoded_rd_address             <= instruction[23:16];
            decoded_rs_address             <= instruction[15:8];
            decoded_rt_address             <= instruction[7:0];
            decoded_predicate_address      <= instruction[26:25];
            decoded_immediate              <= instruction[DATA_BITS-1:0];
            decoded_nzp                    <= instruction[23:21];
            decoded_reg_write_enable       <= nx_reg_write_enable;
            decoded_predicate_write_enable <= nx_predicate_write_enable;
            decoded_nzp_write_enable       <= nx_nzp_write_enable;
            decoded_reg_input_mux          <= nx_reg_input_mux;
            decoded_predicate_on           <= instruction[27];
            decoded_always_execute         <= instruction[27] & instruction[24];
            decoded_mem_read_enable        <= nx_mem_read_enable;
            decoded_mem_write_enable       <= nx_mem_write_enable;
            decoded_tensor_enable          <= nx_tensor_enable;
            decoded_alu_arithmetic_mux     <= nx_alu_arithmetic_mux;
            decoded_alu_output_mux         <= nx_alu_output_mux;
            decoded_pc_mux                 <= nx_pc_mux;
            decoded_ret                    <= nx_ret;
        end
    end

`ifdef DECODER_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky until reset so software can inspect the fault after the offending instruction retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (decode_edge && illegal_op) begin
            illegal_q <= 1'b1;
        end
    end

    assign decoded_illegal = illegal_q;
`else
    logic unused_illegal_op;
    assign unused_illegal_op = illegal_op;
    assign decoded_illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_decoded_control.sv
// Self-checking bench for decoded_control: directed vectors plus randomized traffic against a behavioural decode model.
// Define DECODER_ILLEGAL_TRAP_EN for both RTL and bench to exercise the illegal-opcode trap.
module tb_decoded_control;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_DECODE  = 3'b010;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;

    typedef struct packed {
        logic [7:0] rd;
        logic [7:0] rs;
        logic [7:0] rt;
        logic [1:0] pa;
        logic [7:0] imm;
        logic [2:0] nzp;
        logic       rwe;
        logic       pwe;
        logic       nwe;
        logic [1:0] rim;
        logic       pon;
        logic       aex;
        logic       mre;
        logic       mwe;
        logic       ten;
        logic [1:0] arith;
        logic       aom;
        logic       pc;
        logic       ret;
        logic       ill;
    } out_t;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic [31:0] instruction;
    logic [7:0]  decoded_rd_address, decoded_rs_address, decoded_rt_address;
    logic [1:0]  decoded_predicate_address;
    logic [7:0]  decoded_immediate;
    logic [2:0]  decoded_nzp;
    logic        decoded_reg_write_enable, decoded_predicate_write_enable, decoded_nzp_write_enable;
    logic [1:0]  decoded_reg_input_mux;
    logic        decoded_predicate_on, decoded_always_execute;
    logic        decoded_mem_read_enable, decoded_mem_write_enable, decoded_tensor_enable;
    logic [1:0]  decoded_alu_arithmetic_mux;
    logic        decoded_alu_output_mux, decoded_pc_mux, decoded_ret, decoded_illegal;

    out_t obs;
    out_t exp_o;
    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
`ifdef DECODER_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    decoded_control #(.DATA_BITS(8)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .core_state                     (core_state),
        .instruction                    (instruction),
        .decoded_rd_address             (decoded_rd_address),
        .decoded_rs_address             (decoded_rs_address),
        .decoded_rt_address             (decoded_rt_address),
        .decoded_predicate_address      (decoded_predicate_address),
        .decoded_immediate              (decoded_immediate),
        .decoded_nzp                    (decoded_nzp),
        .decoded_reg_write_enable       (decoded_reg_write_enable),
        .decoded_predicate_write_enable (decoded_predicate_write_enable),
        .decoded_nzp_write_enable       (decoded_nzp_write_enable),
        .decoded_reg_input_mux          (decoded_reg_input_mux),
        .decoded_predicate_on           (decoded_predicate_on),
        .decoded_always_execute         (decoded_always_execute),
        .decoded_mem_read_enable        (decoded_mem_read_enable),
        .decoded_mem_write_enable       (decoded_mem_write_enable),
        .decoded_tensor_enable          (decoded_tensor_enable),
        .decoded_alu_arithmetic_mux     (decoded_alu_arithmetic_mux),
        .decoded_alu_output_mux         (decoded_alu_output_mux),
        .decoded_pc_mux                 (decoded_pc_mux),
        .decoded_ret                    (decoded_ret),
        .decoded_illegal                (decoded_illegal)
    );

    assign obs = {decoded_rd_address, decoded_rs_address, decoded_rt_address,
                  decoded_predicate_address, decoded_immediate, decoded_nzp,
                  decoded_reg_write_enable, decoded_predicate_write_enable,
                  decoded_nzp_write_enable, decoded_reg_input_mux,
                  decoded_predicate_on, decoded_always_execute,
                  decoded_mem_read_enable, decoded_mem_write_enable,
                  decoded_tensor_enable, decoded_alu_arithmetic_mux,
                  decoded_alu_output_mux, decoded_pc_mux, decoded_ret,
                  decoded_illegal};

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what a decode of this word should produce, from the opcode table.
    function automatic out_t model_decode(input logic [31:0] ins, input logic prev_ill);
        out_t o;
        int   op;
        o       = '0;
        op      = int'(ins[31:28]);
        o.rd    = ins[23:16];
        o.rs    = ins[15:8];
        o.rt    = ins[7:0];
        o.pa    = ins[26:25];
        o.imm   = ins[7:0];
        o.nzp   = ins[23:21];
        o.pon   = ins[27];
        o.aex   = ins[27] ? ins[24] : 1'b0;
        if (op == 1) o.pc = 1'b1;
        if (op == 2) begin o.aom = 1'b1; o.nwe = 1'b1; end
        if (op >= 3 && op <= 6) begin o.rwe = 1'b1; o.arith = 2'(op - 3); end
        if (op == 7) begin o.rwe = 1'b1; o.mre = 1'b1; o.rim = 2'd1; end
        if (op == 8) o.mwe = 1'b1;
        if (op == 9) begin o.rwe = 1'b1; o.rim = 2'd2; end
        if (op == 10) begin o.aom = 1'b1; o.pwe = 1'b1; end
        if (op == 11) begin o.ten = 1'b1; o.rwe = 1'b1; o.rim = 2'd3; end
        if (op == 15) o.ret = 1'b1;
        if (int'(ins[23:16]) >= 13) o.rwe = 1'b0;
        o.ill = TRAP & (prev_ill | (op >= 12 && op <= 14));
        return o;
    endfunction

    // driver: apply inputs for one rising edge, then advance the model and settle past the edge
    task automatic drive(input logic [2:0] st, input logic [31:0] ins, input logic rst);
        @(negedge clk);
        reset       = rst;
        core_state  = st;
        instruction = ins;
        @(posedge clk);
        #1;
        if (rst) exp_o = '0;
        else if (st == S_DECODE) exp_o = model_decode(ins, exp_o.ill);
    endtask

    task automatic test_reset();
        drive(S_DECODE, 32'h3005_0102, 1'b1);
        drive(S_DECODE, 32'h3005_0102, 1'b1);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_all_zero got=%h exp=0", obs);
        end
        drive(S_DECODE, 32'h3005_0102, 1'b0);
        checks++;
        if (decoded_rd_address !== 8'd5 || decoded_rs_address !== 8'd1 || decoded_rt_address !== 8'd2 ||
            decoded_reg_write_enable !== 1'b1 || decoded_reg_input_mux !== 2'b00 ||
            decoded_alu_arithmetic_mux !== 2'b00) begin
            errors++;
            $display("FAIL add_after_reset got=%h exp rd=5 rs=1 rt=2 rwe=1 mux=0 arith=0", obs);
        end
        checks++;
        if (obs !== exp_o) begin
            errors++;
            $display("FAIL add_after_reset_model got=%h exp=%h", obs, exp_o);
        end
    endtask

    task automatic test_const_hold();
        out_t held;
        drive(S_DECODE, 32'h9003_00A5, 1'b0);
        checks++;
        if (decoded_immediate !== 8'hA5 || decoded_reg_input_mux !== 2'b10 || decoded_reg_write_enable !== 1'b1) begin
            errors++;
            $display("FAIL const_decode got imm=%h mux=%b rwe=%b exp imm=a5 mux=10 rwe=1",
                     decoded_immediate, decoded_reg_input_mux, decoded_reg_write_enable);
        end
        held = exp_o;
        drive(S_REQUEST, 32'h0, 1'b0);
        drive(S_WAIT, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if (obs !== held) begin
            errors++;
            $display("FAIL const_hold got=%h exp=%h", obs, held);
        end
    endtask

    task automatic test_rd_limit();
        drive(S_DECODE, 32'h30FE_0102, 1'b0);
        checks++;
        if (decoded_reg_write_enable !== 1'b0 || decoded_rd_address !== 8'hFE) begin
            errors++;
            $display("FAIL rd_fe got rwe=%b rd=%h exp rwe=0 rd=fe", decoded_reg_write_enable, decoded_rd_address);
        end
        drive(S_DECODE, 32'h300C_0000, 1'b0);
        checks++;
        if (decoded_reg_write_enable !== 1'b1) begin
            errors++;
            $display("FAIL rd_12 got rwe=%b exp=1", decoded_reg_write_enable);
        end
        drive(S_DECODE, 32'h900D_0000, 1'b0);
        checks++;
        if (decoded_reg_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL rd_13 got rwe=%b exp=0", decoded_reg_write_enable);
        end
    endtask

    task automatic test_predicate();
        drive(S_DECODE, 32'hAA00_0304, 1'b0);
        checks++;
        if (decoded_predicate_write_enable !== 1'b1 || decoded_predicate_address !== 2'b01 ||
            decoded_predicate_on !== 1'b1 || decoded_alu_output_mux !== 1'b1) begin
            errors++;
            $display("FAIL setp got pwe=%b pa=%b pon=%b aom=%b exp 1 01 1 1", decoded_predicate_write_enable,
                     decoded_predicate_address, decoded_predicate_on, decoded_alu_output_mux);
        end
        drive(S_DECODE, 32'h7001_0200, 1'b0);
        checks++;
        if (decoded_predicate_write_enable !== 1'b0 || decoded_mem_read_enable !== 1'b1 ||
            decoded_reg_input_mux !== 2'b01) begin
            errors++;
            $display("FAIL ldr_after_setp got pwe=%b mre=%b mux=%b exp 0 1 01", decoded_predicate_write_enable,
                     decoded_mem_read_enable, decoded_reg_input_mux);
        end
        drive(S_DECODE, 32'h3100_0000, 1'b0);
        checks++;
        if (decoded_always_execute !== 1'b0) begin
            errors++;
            $display("FAIL aex_without_pon got=%b exp=0", decoded_always_execute);
        end
        drive(S_DECODE, 32'h3900_0000, 1'b0);
        checks++;
        if (decoded_always_execute !== 1'b1 || decoded_predicate_on !== 1'b1) begin
            errors++;
            $display("FAIL aex_with_pon got aex=%b pon=%b exp 1 1", decoded_always_execute, decoded_predicate_on);
        end
    endtask

    task automatic test_illegal();
        drive(S_DECODE, 32'hD000_0000, 1'b0);
        checks++;
        if (decoded_illegal !== TRAP || obs !== exp_o) begin
            errors++;
            $display("FAIL illegal_d got=%h exp=%h", obs, exp_o);
        end
        drive(S_DECODE, 32'h0000_0000, 1'b0);
        checks++;
        if (decoded_illegal !== TRAP) begin
            errors++;
            $display("FAIL illegal_sticky got=%b exp=%b", decoded_illegal, TRAP);
        end
        drive(S_IDLE, 32'h0, 1'b1);
        checks++;
        if (decoded_illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset_clear got=%b exp=0", decoded_illegal);
        end
    endtask

    task automatic test_reset_mid();
        drive(S_DECODE, 32'hB001_0203, 1'b0);
        drive(S_REQUEST, 32'hB001_0203, 1'b1);
        drive(S_WAIT, 32'hB001_0203, 1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=0", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        out_t        e;
        for (int i = 0; i < 16; i++) begin
            ins = {4'(i), 28'($urandom)};
            drive(S_DECODE, ins, 1'b0);
            exp_q.push_back(exp_o);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back i=%0d ins=%h got=%h exp=%h", i, ins, obs, e);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  st;
        logic [31:0] ins;
        logic        rst;
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 2) == 0) ? S_DECODE : 3'($urandom_range(0, 7));
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) ins[23:16] = 8'($urandom_range(10, 15));
            rst = ($urandom_range(0, 19) == 0);
            drive(st, ins, rst);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL random i=%0d st=%0d ins=%h rst=%b got=%h exp=%h", i, st, ins, rst, obs, exp_o);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        core_state  = S_IDLE;
        instruction = '0;
        exp_o       = '0;
        test_reset();
        test_const_hold();
        test_rd_limit();
        test_predicate();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
